// File: rtl/alu_flags_unit.sv
// Status-flag register and condition evaluator for the 8-bit core.
// Holds the architectural C/Z/V/N flags, saves/restores them on a small
// shadow stack for interrupt entry/return, and evaluates condition codes
// against the held flags with a one-cycle registered result.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flag_we, flag_mask       masked flag update from the ALU, {C,Z,V,N}
//   alu_c/z/v/n              ALU flag results (C = borrow on subtract)
//   sw_we, sw_data           direct flag write, {C,Z,V,N}
//   push, pop                shadow stack save / restore
//   cond_valid, cond         condition evaluation request and code
//   flags                    architectural flags {C,Z,V,N}
//   take, take_valid         registered condition result, valid strobe
//   stk_empty, stk_full      stack occupancy (combinational from sp)
//   stk_err                  sticky overflow/underflow indicator
module alu_flags_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic [3:0] flag_mask,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n,
  input  logic       sw_we,
  input  logic [3:0] sw_data,
  input  logic       push,
  input  logic       pop,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic [3:0] flags,
  output logic       take,
  output logic       take_valid,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_err
);

  // Storage is sized to the full pointer range so every sp value indexes legally.
  localparam int unsigned SLOTS = 1 << PTR_W;

  logic [3:0]       stk [SLOTS];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_n;
  logic [PTR_W-1:0] top_idx;
  logic [3:0]       top_c;
  logic [3:0]       alu_vec;
  logic [3:0]       upd_c;
  logic [3:0]       flags_n;
  logic             err_n;
  logic             stk_we;
  logic [PTR_W-1:0] stk_wa;
  logic [3:0]       stk_wd;
  logic             cond_res;

  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == PTR_W'(DEPTH));
  assign top_idx   = sp - PTR_W'(1);
  assign top_c     = stk[top_idx];
  assign alu_vec   = {alu_c, alu_z, alu_v, alu_n};

  // Non-stack flag update: sw_we beats the masked ALU write.
  always_comb begin
    upd_c = flags;
    if (sw_we)
      upd_c = sw_data;
    else if (flag_we)
      upd_c = (flags & ~flag_mask) | (alu_vec & flag_mask);
  end

  // Stack control; a successful pop (or swap) overrides the non-stack update.
  always_comb begin
    flags_n = upd_c;
    sp_n    = sp;
    err_n   = stk_err;
    stk_we  = 1'b0;
    stk_wa  = sp;
    stk_wd  = flags;
    if (push && pop) begin
      if (!stk_empty) begin
        flags_n = top_c;
        stk_we  = 1'b1;
        stk_wa  = top_idx;
      end else begin
        err_n = 1'b1;
      end
    end else if (push) begin
      if (!stk_full) begin
        stk_we = 1'b1;
        sp_n   = sp + PTR_W'(1);
      end else begin
        err_n = 1'b1;
      end
    end else if (pop) begin
      if (!stk_empty) begin
        flags_n = top_c;
        sp_n    = top_idx;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  // Condition evaluation against the currently registered flags.
  always_comb begin
    cond_res = 1'b0;
    case (cond)
      4'd0:    cond_res = flags[2];
      4'd1:    cond_res = ~flags[2];
      4'd2:    cond_res = flags[3];
      4'd3:    cond_res = ~flags[3];
      4'd4:    cond_res = flags[0];
      4'd5:    cond_res = ~flags[0];
      4'd6:    cond_res = flags[1];
      4'd7:    cond_res = ~flags[1];
      4'd8:    cond_res = ~flags[3] & ~flags[2];
      4'd9:    cond_res = flags[3] | flags[2];
      4'd10:   cond_res = (flags[0] == flags[1]);
      4'd11:   cond_res = (flags[0] != flags[1]);
      4'd12:   cond_res = ~flags[2] & (flags[0] == flags[1]);
      4'd13:   cond_res = flags[2] | (flags[0] != flags[1]);
      4'd14:   cond_res = 1'b1;
      default: cond_res = 1'b0;
    endcase
  end

  // Architectural state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags      <= 4'b0000;
      sp         <= '0;
      stk_err    <= 1'b0;
      take       <= 1'b0;
      take_valid <= 1'b0;
    end else begin
      flags      <= flags_n;
      sp         <= sp_n;
      stk_err    <= err_n;
      take_valid <= cond_valid;
      if (cond_valid)
        take <= cond_res;
    end
  end

  // Stack contents carry no reset value.
  always_ff @(posedge clk) begin
    if (stk_we)
      stk[stk_wa] <= stk_wd;
  end

endmodule

// File: doc/alu_flags_unit.md
Name: alu_flags_unit

Overview:
Status-flag register and condition evaluator for the 8-bit core. It consumes the C/Z/V/N flags the ALU arithmetic circuits produce and holds them architecturally. It provides a small shadow stack that saves and restores flags on interrupt entry and return. It evaluates branch and conditional-execution codes against the held flags and returns a registered take/not-take result.

Parameters:
DEPTH, 4, shadow-stack entries (1..8)
PTR_W, 3, stack pointer width; must satisfy 2**PTR_W >= DEPTH+1

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flag_we  input  1  ALU result valid; update flags selected by flag_mask
flag_mask  input  4  per-flag update enable, bit order {C,Z,V,N} = [3:0]
alu_c  input  1  ALU carry/borrow (for subtract: 1 = borrow, a < b unsigned)
alu_z  input  1  ALU zero flag
alu_v  input  1  ALU signed overflow
alu_n  input  1  ALU negative (result MSB)
sw_we  input  1  direct flag write (flag-load instruction)
sw_data  input  4  value for direct write, {C,Z,V,N}
push  input  1  save current flags to shadow stack (interrupt entry)
pop  input  1  restore flags from shadow stack (interrupt return)
cond_valid  input  1  condition evaluation request
cond  input  4  condition code
flags  output  4  architectural flags {C,Z,V,N}
take  output  1  registered condition result
take_valid  output  1  take is valid this cycle
stk_empty  output  1  stack holds 0 entries
stk_full  output  1  stack holds DEPTH entries
stk_err  output  1  sticky: overflow or underflow occurred

Behaviour:
- Reset (async, immediate): flags=0000, take=0, take_valid=0, stack pointer=0, stk_empty=1, stk_full=0, stk_err=0. Stack contents are don't-care.
- Flag next-state priority: pop restore > sw_we > flag_we. Each level applies to all four bits, except that flag_we applies per bit under flag_mask (mask bit 0 keeps the old bit).
- push alone, stack not full: entry[sp] <- current (pre-update) flags, sp+1. A flag_we or sw_we in the same cycle still updates flags.
- pop alone, stack not empty: flags <- entry[sp-1], sp-1. A same-cycle flag_we or sw_we is discarded.
- push and pop together, stack not empty: swap. flags <- top entry, top entry <- current flags, sp unchanged.
- push and pop together, stack empty: no stack change; stk_err set; flags follow sw_we/flag_we.
- push when full: ignored and stk_err set. sp does not wrap.
- pop when empty: ignored, flags unchanged by the pop, stk_err set.
- stk_err clears only on rst.
- stk_empty = (sp==0) and stk_full = (sp==DEPTH), both driven combinationally from the registered sp.
- Condition evaluation:
  - Latency 1. When cond_valid is high in cycle t, take_valid=1 and take=result in cycle t+1.
  - The result uses the registered flags of cycle t, i.e. pre-update; there is no forwarding of same-cycle flag_we.
  - When cond_valid=0, take_valid=0 next cycle and take holds its last value.
- Condition codes (C = borrow):
  - 0 EQ Z
  - 1 NE !Z
  - 2 LO C
  - 3 HS !C
  - 4 MI N
  - 5 PL !N
  - 6 VS V
  - 7 VC !V
  - 8 HI !C&!Z
  - 9 LS C|Z
  - 10 GE N==V
  - 11 LT N!=V
  - 12 GT !Z&(N==V)
  - 13 LE Z|(N!=V)
  - 14 AL 1
  - 15 NV 0
- Reset mid-operation: everything returns to reset values asynchronously, and any take_valid in flight is dropped.

Test Plan:
- Reset, then flag_we=1, mask=1111, {c,z,v,n}=0100 (5-5) -> flags=0100 next cycle; cond=EQ -> take=1 one cycle later; cond=HI -> take=0.
- flags=0000, flag_we with alu=1011, mask=1001 -> flags=1001 (Z and V held at 0).
- 8'h80 - 8'h01 flags {C0,Z0,V1,N0}, then cond=GE -> take=0 and cond=LT -> take=1; same cycle flag_we=1 with 0000 and cond=LT -> take uses old flags, take=1.
- Push 4 distinct values (0001,0010,0100,1000) -> stk_full=1; a 5th push -> stk_err=1, sp unchanged; 4 pops -> flags restored 1000,0100,0010,0001; a 5th pop -> flags stay 0001, stk_empty=1.
- Flags=1010, one entry 0101; push+pop together -> flags=0101, top=1010, sp=1; pop -> flags=1010.
- pop with sw_we=1, sw_data=1111 and entry 0011 -> flags=0011. Assert rst while cond_valid is in flight -> take_valid=0 immediately and flags=0000.
